sparc_exu_bypscbd: RTL and testbench
====================================

Name: sparc_exu_bypscbd

Overview:
- Parametrised bypass scoreboard for the EXU operand path.
- Tracks in-flight register writers through NSTG pipeline stages in an internal per-stage tag pipeline, with configurable thread count, register-address width and operand count.
- For every decode source operand, produces a one-hot bypass select (stages plus register file) and a stall request when the matching producer's result is not yet available.
- Sits between decode/issue and the bypass muxes. Supersedes the fixed four-source, single-operand comparator logic.

Parameters:
- NSTG, 4, number of tracked producer stages (stage 0 = youngest, E); range 2..8
- NOPS, 3, number of source operands evaluated per cycle
- TIDW, 2, thread id width
- RW, 5, register address width

Ports:
- rclk  in  1  clock
- reset  in  1  asynchronous active-high reset
- hold  in  1  pipeline stall; tag pipeline does not advance
- iss_vld  in  1  instruction entering stage 0 this edge
- iss_wen  in  1  entering instruction writes a register
- iss_tid  in  TIDW  thread of entering instruction
- iss_rd  in  RW  destination of entering instruction
- kill  in  NSTG  per-stage flush; clears that stage's valid at the edge
- stg_rdy  in  NSTG  result of stage i is available on the bypass bus this cycle
- rs_tid  in  TIDW  thread of decode instruction
- rs  in  NOPS*RW  packed source addresses, operand k at [k*RW +: RW]
- use_other  in  NOPS  operand k takes the alternate source; no bypass, no stall
- byp_sel  out  NOPS*(NSTG+1)  one-hot per operand; bit i (i<NSTG) = stage i, bit NSTG = register file
- byp_stall  out  NOPS  operand k must wait (producer not ready)
- stall_any  out  1  OR of byp_stall
- stg_vld  out  NSTG  current per-stage valid (visibility/debug)

Behaviour:
Tag pipeline:
- Each stage holds {vld, tid, rd}.
- At each rclk edge with hold=0:
  - stage0 <= {iss_vld & iss_wen & (iss_rd!=0), iss_tid, iss_rd}.
  - stage i <= stage i-1 for i>0.
  - The oldest stage's contents are discarded.
- At each rclk edge with hold=1: contents are unchanged.
- kill[i]=1 at an edge forces the post-edge valid of the entry that was in stage i to 0, irrespective of hold:
  - With hold=0, the entry moves to stage i+1 invalid.
  - With hold=1, stage i is cleared in place.
  - kill is sampled against pre-edge stage indices.
- reset asserted (asynchronous): all stage valid bits 0, tid/rd 0, effective immediately.
- Deasserting reset takes effect at the next edge.

Operand evaluation (combinational from current state, zero added latency):
- match_k,i = stg vld[i] & (stage tid == rs_tid) & (stage rd == rs_k).
- eligible_k = (rs_k != 0) & ~use_other[k].
- Priority: lowest stage index (youngest) wins.
  - win_k = min i with match_k,i, if any.
  - Older matching stages are ignored.
- Output decode:
  - If ~eligible_k: byp_sel_k = 0 when use_other[k]=1; RF bit only when rs_k==0. byp_stall[k]=0.
  - Else if no match: RF bit only, byp_stall[k]=0.
  - Else if stg_rdy[win]=1: stage-win bit only, byp_stall[k]=0.
  - Else: RF bit only, byp_stall[k]=1 (no fallback to older stage).
- byp_sel_k always has at most one bit set.
- stall_any = |byp_stall.
- stg_vld mirrors stage valid bits.
- Outputs after reset with use_other=0: byp_sel = RF only for every operand, byp_stall=0, stall_any=0, stg_vld=0.

Boundary cases:
- Same rd written by two stages: youngest wins, even if not ready (stall).
- Entry leaving the oldest stage is no longer visible; the register file is then correct.
- iss_vld=1 with hold=1: entry not captured; the issuer must re-present it.
- Killed stage matches nothing in the same cycle after the edge.
- Reset mid-operation: in-flight tags discarded, no spurious stall.

Test Plan:
- Reset, then rs0=5, rs_tid=0, all stg_rdy=1 -> byp_sel_0 = RF (bit 4), stall_any=0, stg_vld=0000.
- Issue rd=5 tid=1, wen=1, then 2 idle cycles; rs0=5, rs_tid=1, stg_rdy=1111 -> byp_sel_0 = stage2 only. With rs_tid=0 -> RF only.
- Issue rd=7 twice on consecutive cycles (tid 0); rs1=7 -> stage0 selected, not stage1. With stg_rdy[0]=0 -> byp_stall[1]=1, byp_sel_1=RF.
- rd=3 in stage1, kill=0010 at the edge -> next cycle rs=3 selects RF, stg_vld[2]=0.
- hold=1 for 3 cycles with rd=9 in stage0 -> stage0 stays matched. iss_vld=1 during hold is not captured; after hold release the pipeline advances by one.
- Operand with rs=0 or use_other=1 while a stage holds rd=0 attempt or a match -> rs=0 gives RF, use_other gives byp_sel=0, no stall. Assert reset mid-stream -> stg_vld=0 immediately.

Source files
------------

// File: rtl/sparc_exu_bypscbd_if.sv
// Bundle between decode/issue, the bypass scoreboard and the bypass muxes.
// The master drives issue/decode state; the slave (scoreboard) returns selects and stalls.
interface sparc_exu_bypscbd_if #(
  parameter int unsigned NSTG = 4,
  parameter int unsigned NOPS = 3,
  parameter int unsigned TIDW = 2,
  parameter int unsigned RW   = 5
);
  logic                     hold;
  logic                     iss_vld;
  logic                     iss_wen;
  logic [TIDW-1:0]          iss_tid;
  logic [RW-1:0]            iss_rd;
  logic [NSTG-1:0]          kill;
  logic [NSTG-1:0]          stg_rdy;
  logic [TIDW-1:0]          rs_tid;
  logic [NOPS*RW-1:0]       rs;
  logic [NOPS-1:0]          use_other;
  logic [NOPS*(NSTG+1)-1:0] byp_sel;
  logic [NOPS-1:0]          byp_stall;
  logic                     stall_any;
  logic [NSTG-1:0]          stg_vld;

  modport master (
    output hold, iss_vld, iss_wen, iss_tid, iss_rd, kill, stg_rdy, rs_tid, rs, use_other,
    input  byp_sel, byp_stall, stall_any, stg_vld
  );

  modport slave (
    input  hold, iss_vld, iss_wen, iss_tid, iss_rd, kill, stg_rdy, rs_tid, rs, use_other,
    output byp_sel, byp_stall, stall_any, stg_vld
  );
endinterface

// File: rtl/sparc_exu_bypscbd.sv
// Bypass scoreboard: tracks in-flight register writers per stage and derives a one-hot
// bypass select plus stall request for each decode source operand.
module sparc_exu_bypscbd #(
  parameter int unsigned NSTG = 4,
  parameter int unsigned NOPS = 3,
  parameter int unsigned TIDW = 2,
  parameter int unsigned RW   = 5
) (
  input logic                rclk,
  input logic                reset,
  sparc_exu_bypscbd_if.slave bif
);

  localparam int unsigned SW = NSTG + 1;
  localparam logic [SW-1:0] RfSel = {1'b1, {NSTG{1'b0}}};

  logic [NSTG-1:0]           vld_q, vld_d;
  logic [NSTG-1:0][TIDW-1:0] tid_q, tid_d;
  logic [NSTG-1:0][RW-1:0]   rd_q, rd_d;

  // Kill applies to pre-edge stage indices: in place under hold, on the shifted entry otherwise.
  always_comb begin
    vld_d = vld_q & ~bif.kill;
    tid_d = tid_q;
    rd_d  = rd_q;
    if (!bif.hold) begin
      vld_d[0] = bif.iss_vld & bif.iss_wen & (bif.iss_rd != '0);
      tid_d[0] = bif.iss_tid;
      rd_d[0]  = bif.iss_rd;
      for (int i = 1; i < NSTG; i++) begin
        vld_d[i] = vld_q[i-1] & ~bif.kill[i-1];
        tid_d[i] = tid_q[i-1];
        rd_d[i]  = rd_q[i-1];
      end
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tid_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      tid_q <= tid_d;
      rd_q  <= rd_d;
    end
  end

  logic [NOPS*SW-1:0] byp_sel_c;
  logic [NOPS-1:0]    byp_stall_c;

  always_comb begin
    logic [RW-1:0]   rs_k;
    logic            hit;
    logic            hit_rdy;
    logic [NSTG-1:0] hit_oh;
    logic [SW-1:0]   sel_k;
    byp_sel_c   = '0;
    byp_stall_c = '0;
    rs_k        = '0;
    hit         = 1'b0;
    hit_rdy     = 1'b0;
    hit_oh      = '0;
    sel_k       = '0;
    for (int unsigned k = 0; k < NOPS; k++) begin
      rs_k    = bif.rs[k*RW +: RW];
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_oh  = '0;
      // Scan oldest to youngest so the youngest match overwrites and wins.
      for (int i = NSTG - 1; i >= 0; i--) begin
        if (vld_q[i] && (tid_q[i] == bif.rs_tid) && (rd_q[i] == rs_k)) begin
          hit     = 1'b1;
          hit_rdy = bif.stg_rdy[i];
          hit_oh  = '0;
          hit_oh[i] = 1'b1;
        end
      end
      if (bif.use_other[k]) begin
        sel_k = '0;
      end else if ((rs_k == '0) || !hit) begin
        sel_k = RfSel;
      end else if (hit_rdy) begin
        sel_k = {1'b0, hit_oh};
      end else begin
        // Youngest producer not ready: never fall back to an older, stale copy.
        sel_k = RfSel;
        byp_stall_c[k] = 1'b1;
      end
      byp_sel_c[k*SW +: SW] = sel_k;
    end
  end

  assign bif.byp_sel   = byp_sel_c;
  assign bif.byp_stall = byp_stall_c;
  assign bif.stall_any = |byp_stall_c;
  assign bif.stg_vld   = vld_q;

endmodule

// File: tb/tb_sparc_exu_bypscbd.sv
// Directed, table-driven bench for the bypass scoreboard (NSTG=4, NOPS=3, TIDW=2, RW=5).
module tb_sparc_exu_bypscbd;

  localparam int unsigned NSTG = 4;
  localparam int unsigned NOPS = 3;
  localparam int unsigned TIDW = 2;
  localparam int unsigned RW   = 5;

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] S0 = 5'b00001;
  localparam logic [4:0] S1 = 5'b00010;
  localparam logic [4:0] S2 = 5'b00100;
  localparam logic [4:0] N  = 5'b00000;

  typedef struct {
    logic        hold;
    logic        iss_vld;
    logic        iss_wen;
    logic [1:0]  iss_tid;
    logic [4:0]  iss_rd;
    logic [3:0]  kill;
    logic [1:0]  rs_tid;
    logic [14:0] rs;
    logic [2:0]  use_other;
    logic [3:0]  rdy;
    logic [14:0] sel;
    logic [2:0]  stall;
    logic [3:0]  vld;
  } vec_t;

  logic rclk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vq[$];

  always #5 rclk = ~rclk;

  sparc_exu_bypscbd_if #(.NSTG(NSTG), .NOPS(NOPS), .TIDW(TIDW), .RW(RW)) bif ();

  sparc_exu_bypscbd #(.NSTG(NSTG), .NOPS(NOPS), .TIDW(TIDW), .RW(RW)) dut (
    .rclk  (rclk),
    .reset (reset),
    .bif   (bif)
  );

  function automatic vec_t mk(logic h, logic v, logic w, logic [1:0] t, logic [4:0] rd,
                              logic [3:0] kl, logic [1:0] rt, logic [4:0] r0, logic [4:0] r1,
                              logic [4:0] r2, logic [2:0] uo, logic [3:0] rdy, logic [4:0] s0,
                              logic [4:0] s1, logic [4:0] s2, logic [2:0] st, logic [3:0] vl);
    vec_t x;
    x.hold = h; x.iss_vld = v; x.iss_wen = w; x.iss_tid = t; x.iss_rd = rd; x.kill = kl;
    x.rs_tid = rt; x.rs = {r2, r1, r0}; x.use_other = uo; x.rdy = rdy;
    x.sel = {s2, s1, s0}; x.stall = st; x.vld = vl;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    bif.hold = x.hold; bif.iss_vld = x.iss_vld; bif.iss_wen = x.iss_wen;
    bif.iss_tid = x.iss_tid; bif.iss_rd = x.iss_rd; bif.kill = x.kill;
    bif.rs_tid = x.rs_tid; bif.rs = x.rs; bif.use_other = x.use_other; bif.stg_rdy = x.rdy;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 4'hf, R, R, R, 0, 0);
    drive(idle);
    #1 reset = 1'b1;
    #1;
    chk("reset_sel", 32'(bif.byp_sel), 32'({R, R, R}));
    chk("reset_stall_any", 32'(bif.stall_any), 32'd0);
    chk("reset_stg_vld", 32'(bif.stg_vld), 32'd0);
    @(posedge rclk);
    #2 reset = 1'b0;
    #1;
    chk("post_reset_sel", 32'(bif.byp_sel), 32'({R, R, R}));

    //        h v w t rd kill   rt r0 r1 r2 uo     rdy      s0 s1 s2 stall   vld
    vq.push_back(mk(0, 1, 1, 1, 5, 0,      1, 5, 0, 0, 0,     4'hf,    S0, R,  R,  3'b000, 4'b0001));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      1, 5, 0, 0, 0,     4'hf,    S1, R,  R,  3'b000, 4'b0010));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      1, 5, 0, 0, 0,     4'hf,    S2, R,  R,  3'b000, 4'b0100));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      0, 5, 0, 0, 0,     4'hf,    R,  R,  R,  3'b000, 4'b1000));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      1, 5, 0, 0, 0,     4'hf,    R,  R,  R,  3'b000, 4'b0000));
    vq.push_back(mk(0, 1, 1, 0, 7, 0,      0, 0, 7, 0, 0,     4'hf,    R,  S0, R,  3'b000, 4'b0001));
    vq.push_back(mk(0, 1, 1, 0, 7, 0,      0, 0, 7, 0, 0,     4'hf,    R,  S0, R,  3'b000, 4'b0011));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 7, 0, 0,     4'b1110, R,  R,  R,  3'b010, 4'b0011));
    vq.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 7, 0, 0,     4'b1101, R,  S0, R,  3'b000, 4'b0011));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 7, 0, 0,     4'b1101, R,  R,  R,  3'b010, 4'b0110));
    vq.push_back(mk(0, 1, 1, 2, 3, 0,      2, 3, 7, 0, 0,     4'hf,    S0, R,  R,  3'b000, 4'b1101));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      2, 3, 7, 0, 0,     4'hf,    S1, R,  R,  3'b000, 4'b1010));
    vq.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 2, 3, 0, 0, 0,    4'hf,    R,  R,  R,  3'b000, 4'b0000));
    vq.push_back(mk(0, 1, 1, 1, 9, 0,      1, 0, 0, 9, 0,     4'hf,    R,  R,  S0, 3'b000, 4'b0001));
    vq.push_back(mk(1, 1, 1, 1, 11, 0,     1, 0, 11, 9, 0,    4'hf,    R,  R,  S0, 3'b000, 4'b0001));
    vq.push_back(mk(1, 1, 1, 1, 11, 0,     1, 0, 11, 9, 0,    4'hf,    R,  R,  S0, 3'b000, 4'b0001));
    vq.push_back(mk(1, 1, 1, 1, 11, 0,     1, 0, 11, 9, 0,    4'hf,    R,  R,  S0, 3'b000, 4'b0001));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,      1, 0, 11, 9, 0,    4'hf,    R,  R,  S1, 3'b000, 4'b0010));
    vq.push_back(mk(1, 0, 0, 0, 0, 4'b0010, 1, 0, 11, 9, 0,   4'hf,    R,  R,  R,  3'b000, 4'b0000));
    vq.push_back(mk(0, 1, 1, 0, 0, 0,      0, 0, 0, 9, 3'b100, 4'hf,   R,  R,  N,  3'b000, 4'b0000));
    vq.push_back(mk(0, 1, 1, 0, 4, 0,      0, 4, 4, 0, 3'b001, 4'hf,   N,  S0, R,  3'b000, 4'b0001));
    vq.push_back(mk(0, 1, 0, 0, 6, 0,      0, 6, 4, 0, 0,     4'hf,    R,  S1, R,  3'b000, 4'b0010));

    foreach (vq[j]) begin
      drive(vq[j]);
      @(posedge rclk);
      #2;
      chk($sformatf("v%0d_sel", j), 32'(bif.byp_sel), 32'(vq[j].sel));
      chk($sformatf("v%0d_stall", j), 32'(bif.byp_stall), 32'(vq[j].stall));
      chk($sformatf("v%0d_stall_any", j), 32'(bif.stall_any), 32'(|vq[j].stall));
      chk($sformatf("v%0d_stg_vld", j), 32'(bif.stg_vld), 32'(vq[j].vld));
    end

    // Stage1 holds rd4 tid0; make it not ready, then reset mid-stream.
    bif.iss_vld = 1'b0;
    bif.stg_rdy = 4'b0000;
    #1;
    chk("pre_reset_stall", 32'(bif.byp_stall), 32'b010);
    chk("pre_reset_stall_any", 32'(bif.stall_any), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_stg_vld", 32'(bif.stg_vld), 32'd0);
    chk("mid_reset_stall_any", 32'(bif.stall_any), 32'd0);
    chk("mid_reset_sel", 32'(bif.byp_sel), 32'({R, R, R}));
    bif.iss_vld = 1'b1; bif.iss_wen = 1'b1; bif.iss_tid = 2'd0; bif.iss_rd = 5'd2;
    @(posedge rclk);
    #2;
    chk("reset_blocks_issue", 32'(bif.stg_vld), 32'd0);
    reset = 1'b0;
    bif.rs = {5'd0, 5'd0, 5'd2};
    bif.stg_rdy = 4'hf;
    @(posedge rclk);
    #2;
    bif.iss_vld = 1'b0;
    chk("post_release_stg_vld", 32'(bif.stg_vld), 32'b0001);
    chk("post_release_sel", 32'(bif.byp_sel), 32'({R, R, S0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
